// File: rtl/gpio_pkg.sv
// Shared constants and types for the Avalon-MM GPIO bank.
package gpio_pkg;

  // Avalon slave data bus width
  localparam int AVS_DW = 32;

  // Word address of a register within the bank
  typedef logic [2:0] gpio_addr_t;

  localparam gpio_addr_t ADDR_DATA_IN  = 3'd0;
  localparam gpio_addr_t ADDR_DATA_OUT = 3'd1;
  localparam gpio_addr_t ADDR_IRQ_MASK = 3'd2;
  localparam gpio_addr_t ADDR_EDGE_CAP = 3'd3;
  localparam gpio_addr_t ADDR_RISE_EN  = 3'd4;
  localparam gpio_addr_t ADDR_FALL_EN  = 3'd5;

endpackage

// File: rtl/debounce_bit.sv
// One input channel: two-flop synchroniser followed by a stability counter.
// The debounced value only follows the synchronised input after it has
// disagreed with it for DEBOUNCE_CYCLES consecutive cycles; any agreement
// in between restarts the count.
module debounce_bit #(
  parameter  int DEBOUNCE_CYCLES = 500000,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic Clk,
  input  logic Reset,
  input  logic raw_i,
  output logic deb_o
);

  logic             sync1_q;
  logic             sync2_q;
  logic             deb_q;
  logic             deb_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Stability counter: reset on agreement, accept after the full window
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      deb_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchroniser, debounced value and counter registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/avalon_gpio_bank.sv
// Avalon-MM slave GPIO bank: debounced inputs with edge capture and a
// maskable level interrupt, plus a host-writable output register.
//
// Bus handshake: there is no waitrequest. A write is accepted on every
// cycle with avs_chipselect & avs_write high. A read is accepted on every
// cycle with avs_chipselect & avs_read high and its data is presented on
// avs_readdata exactly one cycle later; avs_readdata holds its value
// otherwise. A simultaneous read and write returns the pre-write value.
module avalon_gpio_bank
  import gpio_pkg::*;
#(
  parameter int IN_WIDTH        = 18,
  parameter int OUT_WIDTH       = 8,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 avs_chipselect,
  input  logic [2:0]           avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [AVS_DW-1:0]    avs_writedata,
  output logic [AVS_DW-1:0]    avs_readdata,
  output logic                 irq,
  input  logic [IN_WIDTH-1:0]  gpio_in,
  output logic [OUT_WIDTH-1:0] gpio_out
);

  logic                 wr_en;
  logic                 rd_en;
  gpio_addr_t           addr;
  logic                 unused_wdata;

  logic [IN_WIDTH-1:0]  din;
  logic [IN_WIDTH-1:0]  d_prev_q;
  logic [OUT_WIDTH-1:0] data_out_q;
  logic [OUT_WIDTH-1:0] data_out_d;
  logic [IN_WIDTH-1:0]  irq_mask_q;
  logic [IN_WIDTH-1:0]  irq_mask_d;
  logic [IN_WIDTH-1:0]  edge_cap_q;
  logic [IN_WIDTH-1:0]  edge_cap_d;
  logic [IN_WIDTH-1:0]  rise_en_q;
  logic [IN_WIDTH-1:0]  rise_en_d;
  logic [IN_WIDTH-1:0]  fall_en_q;
  logic [IN_WIDTH-1:0]  fall_en_d;
  logic [IN_WIDTH-1:0]  rise_ev;
  logic [IN_WIDTH-1:0]  fall_ev;
  logic [IN_WIDTH-1:0]  w1c;
  logic [AVS_DW-1:0]    rdata_d;
  logic [AVS_DW-1:0]    readdata_q;
  logic                 irq_q;

  assign wr_en = avs_chipselect & avs_write;
  assign rd_en = avs_chipselect & avs_read;
  assign addr  = gpio_addr_t'(avs_address);

  // Upper write-data bits beyond the register widths are intentionally ignored
  assign unused_wdata = ^avs_writedata;

  // One debouncer per input channel
  for (genvar i = 0; i < IN_WIDTH; i++) begin : g_deb
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .Clk   (Clk),
      .Reset (Reset),
      .raw_i (gpio_in[i]),
      .deb_o (din[i])
    );
  end

  // Register write decode; EDGE_CAP set from events beats a W1C clear
  always_comb begin
    data_out_d = data_out_q;
    irq_mask_d = irq_mask_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    w1c        = '0;
    if (wr_en) begin
      case (addr)
        ADDR_DATA_OUT: data_out_d = avs_writedata[OUT_WIDTH-1:0];
        ADDR_IRQ_MASK: irq_mask_d = avs_writedata[IN_WIDTH-1:0];
        ADDR_EDGE_CAP: w1c        = avs_writedata[IN_WIDTH-1:0];
        ADDR_RISE_EN:  rise_en_d  = avs_writedata[IN_WIDTH-1:0];
        ADDR_FALL_EN:  fall_en_d  = avs_writedata[IN_WIDTH-1:0];
        default:       ;
      endcase
    end
    rise_ev    = din & ~d_prev_q & rise_en_q;
    fall_ev    = ~din & d_prev_q & fall_en_q;
    edge_cap_d = (edge_cap_q & ~w1c) | rise_ev | fall_ev;
  end

  // Read mux over the current (pre-write) register contents
  always_comb begin
    rdata_d = readdata_q;
    if (rd_en) begin
      case (addr)
        ADDR_DATA_IN:  rdata_d = AVS_DW'(din);
        ADDR_DATA_OUT: rdata_d = AVS_DW'(data_out_q);
        ADDR_IRQ_MASK: rdata_d = AVS_DW'(irq_mask_q);
        ADDR_EDGE_CAP: rdata_d = AVS_DW'(edge_cap_q);
        ADDR_RISE_EN:  rdata_d = AVS_DW'(rise_en_q);
        ADDR_FALL_EN:  rdata_d = AVS_DW'(fall_en_q);
        default:       rdata_d = '0;
      endcase
    end
  end

  // Register file, edge history, read data and interrupt
  always_ff @(posedge Clk) begin
    if (Reset) begin
      data_out_q <= '0;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      d_prev_q   <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      d_prev_q   <= din;
      readdata_q <= rdata_d;
      irq_q      <= |(edge_cap_q & irq_mask_q);
    end
  end

  assign avs_readdata = readdata_q;
  assign irq          = irq_q;
  assign gpio_out     = data_out_q;

endmodule

// File: tb/tb_avalon_gpio_bank.sv
// Directed bench for avalon_gpio_bank with a short debounce window.
module tb_avalon_gpio_bank;

  localparam int IN_W  = 4;
  localparam int OUT_W = 8;
  localparam int DEB   = 4;

  logic             Clk;
  logic             Reset;
  logic             avs_chipselect;
  logic [2:0]       avs_address;
  logic             avs_read;
  logic             avs_write;
  logic [31:0]      avs_writedata;
  logic [31:0]      avs_readdata;
  logic             irq;
  logic [IN_W-1:0]  gpio_in;
  logic [OUT_W-1:0] gpio_out;

  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  avalon_gpio_bank #(
    .IN_WIDTH(IN_W),
    .OUT_WIDTH(OUT_W),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .avs_chipselect(avs_chipselect),
    .avs_address(avs_address),
    .avs_read(avs_read),
    .avs_write(avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata),
    .irq(irq),
    .gpio_in(gpio_in),
    .gpio_out(gpio_out)
  );

  // Clock
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // All driver tasks start and end on a falling edge
  task automatic do_read(input logic [2:0] a, input logic [31:0] exp);
    exp_q.push_back(exp);
    avs_chipselect = 1'b1;
    avs_read       = 1'b1;
    avs_address    = a;
    @(posedge Clk);
    @(negedge Clk);
    avs_chipselect = 1'b0;
    avs_read       = 1'b0;
    check($sformatf("read_addr%0d", a), avs_readdata, exp_q.pop_front());
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] data);
    avs_chipselect = 1'b1;
    avs_write      = 1'b1;
    avs_address    = a;
    avs_writedata  = data;
    @(posedge Clk);
    @(negedge Clk);
    avs_chipselect = 1'b0;
    avs_write      = 1'b0;
  endtask

  task automatic do_rw(input logic [2:0] a, input logic [31:0] data, input logic [31:0] exp);
    exp_q.push_back(exp);
    avs_chipselect = 1'b1;
    avs_write      = 1'b1;
    avs_read       = 1'b1;
    avs_address    = a;
    avs_writedata  = data;
    @(posedge Clk);
    @(negedge Clk);
    avs_chipselect = 1'b0;
    avs_write      = 1'b0;
    avs_read       = 1'b0;
    check("rw_readdata", avs_readdata, exp_q.pop_front());
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  initial begin
    Reset          = 1'b1;
    avs_chipselect = 1'b0;
    avs_address    = '0;
    avs_read       = 1'b0;
    avs_write      = 1'b0;
    avs_writedata  = '0;
    gpio_in        = '0;
    idle(2);

    // Reset state
    check("rst_gpio_out", 32'(gpio_out), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_readdata", avs_readdata, 32'h0);
    Reset = 1'b0;
    for (int a = 0; a < 8; a++) do_read(3'(a), 32'h0);

    // Output register
    do_write(3'd1, 32'hA5);
    check("gpio_out_a5", 32'(gpio_out), 32'hA5);
    do_read(3'd1, 32'hA5);

    // Debounce latency: d rises on edge 6, so reads sampled from edge 7 see it
    gpio_in[0] = 1'b1;
    for (int n = 1; n <= 10; n++) do_read(3'd0, (n >= 7) ? 32'h1 : 32'h0);

    // 3-cycle glitch on bit 1 is rejected
    gpio_in[1] = 1'b1;
    idle(3);
    gpio_in[1] = 1'b0;
    for (int n = 0; n < 10; n++) do_read(3'd0, 32'h1);

    // Rise capture and interrupt on bit 0
    do_write(3'd4, 32'h1);
    do_write(3'd2, 32'h1);
    gpio_in[0] = 1'b0;
    idle(8);
    gpio_in[0] = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      do_read(3'd3, (n >= 8) ? 32'h1 : 32'h0);
      check("rise_irq", 32'(irq), (n >= 8) ? 32'h1 : 32'h0);
    end
    do_write(3'd3, 32'h1);
    check("irq_after_w1c_edge", 32'(irq), 32'h1);
    do_read(3'd3, 32'h0);
    check("irq_cleared", 32'(irq), 32'h0);

    // Fall capture on bit 1, then set-wins against a simultaneous W1C
    do_write(3'd5, 32'h2);
    gpio_in[1] = 1'b1;
    idle(10);
    gpio_in[1] = 1'b0;
    idle(10);
    do_read(3'd3, 32'h2);
    check("fall_irq_masked", 32'(irq), 32'h0);
    do_write(3'd3, 32'h2);
    do_read(3'd3, 32'h0);
    gpio_in[1] = 1'b1;
    idle(10);
    gpio_in[1] = 1'b0;
    idle(6);
    do_write(3'd3, 32'h2);
    do_read(3'd3, 32'h2);
    do_write(3'd3, 32'h2);
    do_read(3'd3, 32'h0);

    // Mask gating of irq, unused addresses, read-only DATA_IN
    do_write(3'd2, 32'h0);
    do_write(3'd4, 32'h5);
    gpio_in[2] = 1'b1;
    idle(10);
    do_read(3'd3, 32'h4);
    check("irq_masked_off", 32'(irq), 32'h0);
    do_write(3'd2, 32'hFFFF_FFF4);
    check("irq_mask_same_cycle", 32'(irq), 32'h0);
    idle(1);
    check("irq_mask_next_cycle", 32'(irq), 32'h1);
    do_read(3'd2, 32'h4);
    do_read(3'd6, 32'h0);
    do_write(3'd6, 32'hFFFF_FFFF);
    do_read(3'd6, 32'h0);
    do_read(3'd7, 32'h0);
    do_write(3'd0, 32'hF);
    do_read(3'd0, 32'h5);
    do_read(3'd5, 32'h2);

    // Simultaneous read/write returns the old value; readdata holds when idle
    do_rw(3'd1, 32'h3C, 32'hA5);
    check("rw_gpio_out", 32'(gpio_out), 32'h3C);
    do_read(3'd1, 32'h3C);
    idle(3);
    check("readdata_hold", avs_readdata, 32'h3C);

    // Capture all four bits, then reset mid-debounce
    do_write(3'd4, 32'hF);
    do_write(3'd5, 32'hF);
    gpio_in = 4'hA;
    idle(10);
    do_read(3'd3, 32'hF);
    check("irq_all_caps", 32'(irq), 32'h1);
    gpio_in = 4'h5;
    idle(3);
    Reset = 1'b1;
    idle(1);
    check("midrst_gpio_out", 32'(gpio_out), 32'h0);
    check("midrst_irq", 32'(irq), 32'h0);
    check("midrst_readdata", avs_readdata, 32'h0);
    Reset = 1'b0;
    for (int n = 1; n <= 10; n++) do_read(3'd0, (n >= 7) ? 32'h5 : 32'h0);
    for (int a = 1; a <= 5; a++) do_read(3'(a), 32'h0);
    check("post_rst_irq", 32'(irq), 32'h0);
    check("post_rst_gpio_out", 32'(gpio_out), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
